cpu_protocol_monitor: RTL and testbench

Synthesizable runtime protocol and latency monitor for `simple_cpu`, the parametrised successor to the simulation-only assertion set. It sits beside the CPU, passively sampling the instruction and memory handshakes. It checks per-opcode-class latency, the handshake rules, the memory response timeout and `done` stickiness. Results are exposed as sticky error flags and saturating counters readable by a debug/status block.

---
 rtl/cpu_protocol_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_cpu_protocol_monitor.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_protocol_monitor.sv
// Passive latency/handshake monitor for simple_cpu with sticky flags and counters.
// Define CPU_MON_HIST_EN to add the per-latency completion histogram.
module cpu_protocol_monitor #(
  parameter int MAX_LAT     = 5,
  parameter int MEM_TIMEOUT = 3,
  parameter int CNT_W       = 16,
  localparam int LAT_W      = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic             instr_ready,
  input  logic [15:0]      instr,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             done,
  input  logic             err_clr,
  output logic [5:0]       err_flags,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [LAT_W-1:0] max_lat,
  output logic             mon_busy,
  input  logic [LAT_W-1:0] hist_sel,
  output logic [CNT_W-1:0] hist_data
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_e;

  typedef enum logic [1:0] {
    C_EX3,
    C_EX4,
    C_MEM,
    C_UND
  } cls_e;

  function automatic cls_e classify(input logic [3:0] op);
    cls_e c;
    unique case (op)
      4'h0, 4'hB, 4'hC, 4'hF: c = C_EX3;
      4'h1, 4'h2, 4'h3, 4'h4,
      4'h5, 4'h6, 4'h7, 4'h8: c = C_EX4;
      4'h9, 4'hA:             c = C_MEM;
      default:                c = C_UND;
    endcase
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] x
  );
    return (&x) ? x : x + CNT_W'(1);
  endfunction

  state_e             state_q;
  cls_e               cls_q;
  logic               halt_q;
  logic [LAT_W-1:0]   lat_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               hs_q;
  logic               done_q;
  logic [5:0]         flags_q;
  logic [CNT_W-1:0]   errc_q;
  logic [CNT_W-1:0]   instc_q;
  logic [LAT_W-1:0]   maxl_q;
  logic [CNT_W-1:0]   hist_q;

  logic       accept;
  logic       active;
  logic       cmpl;
  logic       tmo;
  logic       mem_wait;
  logic       lat_ok;
  logic       lat_one;
  logic [5:0] ev;
  logic       any_ev;

  logic unused_instr;
  assign unused_instr = ^instr[11:0];

  always_comb begin
    accept   = instr_valid && instr_ready;
    active   = state_q == S_ACTIVE;
    cmpl     = active && instr_ready;
    tmo      = active && !instr_ready &&
               (lat_q == LAT_W'(MAX_LAT));
    mem_wait = mem_req && !mem_ready;
    lat_one  = lat_q == LAT_W'(1);
    lat_ok   = 1'b1;
    unique case (cls_q)
      C_EX3:   lat_ok = lat_q == LAT_W'(3);
      C_EX4:   lat_ok = lat_q == LAT_W'(4);
      C_MEM:   lat_ok = lat_q >= LAT_W'(3);
      default: lat_ok = 1'b1;
    endcase
    ev    = '0;
    ev[0] = tmo;
    ev[1] = cmpl && !lat_one && !lat_ok;
    ev[2] = cmpl && lat_one;
    ev[3] = mem_wait &&
            (wait_q == WAIT_W'(MEM_TIMEOUT));
    ev[4] = hs_q && mem_req;
    ev[5] = (cmpl && halt_q && !done) ||
            (done_q && !done);
    any_ev = |ev;
  end

  // Acceptance also covers back-to-back restart from ACTIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      cls_q   <= C_UND;
      halt_q  <= 1'b0;
    end else if (accept) begin
      state_q <= S_ACTIVE;
      lat_q   <= LAT_W'(1);
      cls_q   <= classify(instr[15:12]);
      halt_q  <= instr[15:12] == OP_HALT;
    end else if (cmpl || tmo) begin
      state_q <= S_IDLE;
    end else if (active) begin
      lat_q   <= lat_q + LAT_W'(1);
    end
  end

  // wait_q parks one past the limit so E3 fires once per request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      hs_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (!mem_wait) begin
        wait_q <= '0;
      end else if (wait_q != WAIT_W'(MEM_TIMEOUT + 1)) begin
        wait_q <= wait_q + WAIT_W'(1);
      end
      hs_q   <= mem_req && mem_ready;
      done_q <= done;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      errc_q  <= '0;
      instc_q <= '0;
      maxl_q  <= '0;
    end else if (err_clr) begin
      flags_q <= ev;
      errc_q  <= CNT_W'(any_ev);
      instc_q <= '0;
      maxl_q  <= '0;
    end else begin
      flags_q <= flags_q | ev;
      if (any_ev) errc_q <= sat_inc(errc_q);
      if (cmpl) begin
        instc_q <= sat_inc(instc_q);
        if (lat_q > maxl_q) maxl_q <= lat_q;
      end
    end
  end

`ifdef CPU_MON_HIST_EN
  logic [CNT_W-1:0] bin_q [2**LAT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2**LAT_W; k++) bin_q[k] <= '0;
      hist_q <= '0;
    end else begin
      hist_q <= (hist_sel <= LAT_W'(MAX_LAT)) ?
                bin_q[hist_sel] : '0;
      if (err_clr) begin
        for (int k = 0; k < 2**LAT_W; k++) bin_q[k] <= '0;
      end else if (cmpl) begin
        bin_q[lat_q] <= sat_inc(bin_q[lat_q]);
      end else if (tmo) begin
        bin_q[0] <= sat_inc(bin_q[0]);
      end
    end
  end
`else
  logic unused_hist;
  assign unused_hist = ^hist_sel;
  assign hist_q      = '0;
`endif

  assign err_flags   = flags_q;
  assign err_count   = errc_q;
  assign instr_count = instc_q;
  assign max_lat     = maxl_q;
  assign mon_busy    = state_q == S_ACTIVE;
  assign hist_data   = hist_q;

endmodule

// File: tb/tb_cpu_protocol_monitor.sv
// Scoreboard bench for cpu_protocol_monitor: directed plan plus random traffic
// against a transaction-level reference model.
module tb_cpu_protocol_monitor;

  localparam int MAX_LAT     = 5;
  localparam int MEM_TIMEOUT = 3;
  localparam int CNT_W       = 16;
  localparam int LAT_W       = $clog2(MAX_LAT + 1);
  localparam int CMAX        = 2**CNT_W - 1;
`ifdef CPU_MON_HIST_EN
  localparam bit HIST_ON = 1'b1;
`else
  localparam bit HIST_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             instr_valid;
  logic             instr_ready;
  logic [15:0]      instr;
  logic             mem_req;
  logic             mem_ready;
  logic             done;
  logic             err_clr;
  logic [5:0]       err_flags;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] instr_count;
  logic [LAT_W-1:0] max_lat;
  logic             mon_busy;
  logic [LAT_W-1:0] hist_sel;
  logic [CNT_W-1:0] hist_data;

  cpu_protocol_monitor #(
    .MAX_LAT(MAX_LAT),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .mem_req(mem_req),
    .mem_ready(mem_ready),
    .done(done),
    .err_clr(err_clr),
    .err_flags(err_flags),
    .err_count(err_count),
    .instr_count(instr_count),
    .max_lat(max_lat),
    .mon_busy(mon_busy),
    .hist_sel(hist_sel),
    .hist_data(hist_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int flags;
    int errc;
    int instc;
    int maxl;
    int busy;
    int hist;
  } exp_t;

  exp_t sbq[$];
  int   checks;
  int   failures;

  // Reference model state: one in-flight instruction and its age.
  bit   m_busy;
  int   m_age;
  int   m_op;
  int   m_run;
  bit   m_hs;
  bit   m_done;
  int   m_flags;
  int   m_errc;
  int   m_instc;
  int   m_maxl;
  int   m_bins[MAX_LAT+1];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit lat_legal(input int op, input int lat);
    if (op == 0 || op == 11 || op == 12 || op == 15) return lat == 3;
    if (op >= 1 && op <= 8) return lat == 4;
    if (op == 9 || op == 10) return lat >= 3 && lat <= MAX_LAT;
    return lat <= MAX_LAT;
  endfunction

  function automatic int sat(input int x);
    return (x < CMAX) ? x + 1 : x;
  endfunction

  task automatic model_reset();
    exp_t e;
    m_busy = 0; m_age = 0; m_op = 0; m_run = 0;
    m_hs = 0; m_done = 0; m_flags = 0; m_errc = 0;
    m_instc = 0; m_maxl = 0;
    for (int k = 0; k <= MAX_LAT; k++) m_bins[k] = 0;
    e = '{0, 0, 0, 0, 0, 0};
    sbq.push_back(e);
  endtask

  task automatic model_step(input bit v, input bit r,
                            input logic [15:0] ins, input bit rq,
                            input bit rd, input bit dn,
                            input bit cl, input int sel);
    int   ev;
    bit   cmp;
    bit   tmo;
    int   lat;
    exp_t e;
    ev = 0; cmp = 0; tmo = 0; lat = 0;
    if (!m_busy) begin
      if (v && r) begin
        m_busy = 1; m_age = 1; m_op = int'(ins[15:12]);
      end
    end else if (r) begin
      cmp = 1; lat = m_age;
      if (lat == 1) ev |= 4;
      else if (!lat_legal(m_op, lat)) ev |= 2;
      if (m_op == 15 && !dn) ev |= 32;
      if (v) begin
        m_age = 1; m_op = int'(ins[15:12]);
      end else begin
        m_busy = 0;
      end
    end else if (m_age == MAX_LAT) begin
      ev |= 1; tmo = 1; m_busy = 0;
    end else begin
      m_age++;
    end
    if (rq && !rd) begin
      m_run++;
      if (m_run == MEM_TIMEOUT + 1) ev |= 8;
    end else begin
      m_run = 0;
    end
    if (m_hs && rq) ev |= 16;
    m_hs = rq && rd;
    if (m_done && !dn) ev |= 32;
    m_done = dn;
    e.hist = (HIST_ON && sel <= MAX_LAT) ? m_bins[sel] : 0;
    if (cl) begin
      m_flags = ev;
      m_errc  = (ev != 0) ? 1 : 0;
      m_instc = 0; m_maxl = 0;
      for (int k = 0; k <= MAX_LAT; k++) m_bins[k] = 0;
    end else begin
      m_flags |= ev;
      if (ev != 0) m_errc = sat(m_errc);
      if (cmp) begin
        m_instc = sat(m_instc);
        if (lat > m_maxl) m_maxl = lat;
        m_bins[lat] = sat(m_bins[lat]);
      end
      if (tmo) m_bins[0] = sat(m_bins[0]);
    end
    e.flags = m_flags; e.errc = m_errc; e.instc = m_instc;
    e.maxl = m_maxl; e.busy = int'(m_busy);
    sbq.push_back(e);
  endtask

  task automatic cyc(input bit v, input bit r, input logic [15:0] ins,
                     input bit rq, input bit rd, input bit dn,
                     input bit cl, input int sel);
    @(negedge clk);
    rst_n = 1'b1;
    instr_valid = v; instr_ready = r; instr = ins;
    mem_req = rq; mem_ready = rd; done = dn;
    err_clr = cl; hist_sel = LAT_W'(sel);
    model_step(v, r, ins, rq, rd, dn, cl, sel);
  endtask

  task automatic idle(input bit r, input bit dn, input int sel);
    cyc(1'b0, r, 16'h0000, 1'b0, 1'b0, dn, 1'b0, sel);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 0; instr_ready = 0; instr = '0;
    mem_req = 0; mem_ready = 0; done = 0;
    err_clr = 0; hist_sel = '0;
    model_reset();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("err_flags", int'(err_flags), e.flags);
        chk("err_count", int'(err_count), e.errc);
        chk("instr_count", int'(instr_count), e.instc);
        chk("max_lat", int'(max_lat), e.maxl);
        chk("mon_busy", int'(mon_busy), e.busy);
        chk("hist_data", int'(hist_data), e.hist);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin : driver
    int  rp;
    bit  dn;
    checks = 0; failures = 0;
    rst_n = 1'b0;
    instr_valid = 0; instr_ready = 0; instr = '0;
    mem_req = 0; mem_ready = 0; done = 0;
    err_clr = 0; hist_sel = '0;

    do_reset();
    settle();
    chk("rst_flags", int'(err_flags), 0);
    chk("rst_busy", int'(mon_busy), 0);

    // ADD, latency 4
    cyc(1, 1, 16'h1123, 0, 0, 0, 0, 0);
    repeat (3) idle(0, 0, 0);
    idle(1, 0, 0);
    idle(1, 0, 4);
    settle();
    chk("add_flags", int'(err_flags), 0);
    chk("add_icount", int'(instr_count), 1);
    chk("add_maxlat", int'(max_lat), 4);
    chk("add_bin4", int'(hist_data), HIST_ON ? 1 : 0);

    // NOP, latency 4 -> E1
    cyc(0, 1, 16'h0, 0, 0, 0, 1, 0);
    cyc(1, 1, 16'h0000, 0, 0, 0, 0, 0);
    repeat (3) idle(0, 0, 0);
    idle(1, 0, 0);
    settle();
    chk("nop_flags", int'(err_flags), 2);
    chk("nop_ecount", int'(err_count), 1);

    // LOAD never completes -> E0 once
    cyc(0, 1, 16'h0, 0, 0, 0, 1, 0);
    cyc(1, 1, 16'h9000, 0, 0, 0, 0, 0);
    repeat (8) idle(0, 0, 0);
    idle(0, 0, 0);
    settle();
    chk("load_flags", int'(err_flags), 1);
    chk("load_ecount", int'(err_count), 1);
    chk("load_busy", int'(mon_busy), 0);
    chk("load_bin0", int'(hist_data), HIST_ON ? 1 : 0);

    // memory watchdog
    cyc(0, 1, 16'h0, 0, 0, 0, 1, 0);
    repeat (4) cyc(0, 1, 16'h0, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 16'h0, 1, 0, 0, 0, 0);
    idle(1, 0, 0);
    settle();
    chk("mem4_flags", int'(err_flags), 8);
    chk("mem4_ecount", int'(err_count), 1);
    cyc(0, 1, 16'h0, 0, 0, 0, 1, 0);
    repeat (3) cyc(0, 1, 16'h0, 1, 0, 0, 0, 0);
    cyc(0, 1, 16'h0, 1, 1, 0, 0, 0);
    idle(1, 0, 0);
    settle();
    chk("mem3_flags", int'(err_flags), 0);

    // HALT then done drop with err_clr
    cyc(1, 1, 16'hF000, 0, 0, 0, 0, 0);
    repeat (2) idle(0, 0, 0);
    idle(1, 1, 0);
    settle();
    chk("halt_flags", int'(err_flags), 0);
    cyc(0, 1, 16'h0, 0, 0, 0, 1, 0);
    settle();
    chk("halt_e5", int'(err_flags), 32);
    chk("halt_ecount", int'(err_count), 1);

    // back-to-back, then reset mid-instruction
    cyc(0, 1, 16'h0, 0, 0, 0, 1, 0);
    cyc(1, 1, 16'h1123, 0, 0, 0, 0, 0);
    repeat (3) idle(0, 0, 0);
    cyc(1, 1, 16'h2000, 0, 0, 0, 0, 0);
    settle();
    chk("b2b_icount", int'(instr_count), 1);
    chk("b2b_busy", int'(mon_busy), 1);
    repeat (2) idle(0, 0, 0);
    do_reset();
    settle();
    chk("mid_rst_busy", int'(mon_busy), 0);
    chk("mid_rst_icount", int'(instr_count), 0);
    chk("mid_rst_maxlat", int'(max_lat), 0);
    cyc(1, 1, 16'h1000, 0, 0, 0, 0, 0);
    repeat (3) idle(0, 0, 0);
    idle(1, 0, 0);
    settle();
    chk("post_rst_icount", int'(instr_count), 1);
    chk("post_rst_flags", int'(err_flags), 0);

    // randomized traffic
    rp = 35;
    dn = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) rp = $urandom_range(15, 70);
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        dn = 0;
      end else begin
        if ($urandom_range(0, 9) == 0) dn = ~dn;
        cyc($urandom_range(0, 3) != 0,
            $urandom_range(0, 99) < rp,
            16'($urandom),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0,
            dn,
            $urandom_range(0, 63) == 0,
            $urandom_range(0, 7));
      end
    end

    idle(0, 0, 0);
    repeat (2) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
